// File: rtl/plru_replace_if.sv
// plru_replace_if
//   Lookup/update bus between the cache controller and the pseudo-LRU unit.
//   master (cache controller): drives index, valid_in, access, access_way;
//                              receives victim, victim_is_invalid.
//   slave  (plru_replace):     the reverse.
//   index             - set index for victim lookup and recency update
//   valid_in          - per-way valid bits of the indexed set (bit n = way n)
//   access/access_way - a hit or fill to access_way of set index this cycle
//   victim            - way to replace in the indexed set
//   victim_is_invalid - victim is an invalid way, not the tree's choice
interface plru_replace_if #(
  parameter int INDEX_WIDTH = 3
);
  logic [INDEX_WIDTH-1:0] index;
  logic [7:0]             valid_in;
  logic                   access;
  logic [2:0]             access_way;
  logic [2:0]             victim;
  logic                   victim_is_invalid;

  modport master (
    output index, valid_in, access, access_way,
    input  victim, victim_is_invalid
  );

  modport slave (
    input  index, valid_in, access, access_way,
    output victim, victim_is_invalid
  );
endinterface

// File: rtl/plru_replace.sv
// plru_replace
//   Tree pseudo-LRU replacement for an 8-way set-associative cache.
//   Each set holds a 7-bit tree: b0 root, b1/b2 lower/upper-half nodes,
//   b3..b6 leaf-pair nodes for ways {0,1},{2,3},{4,5},{6,7}. A node bit
//   of 1 points the victim walk at the upper child.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset, clears every tree to 0
//     bus  - plru_replace_if.slave (lookup + update bus)
//   The victim is combinational from index, valid_in and the stored tree
//   (pre-update state when an access hits the same set; no bypass).

// One set's tree. Accessing way w makes every node on w's path point
// away from w.
module plru_tree_set (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [2:0] way,
  output logic [6:0] tree
);
  logic [6:0] tree_nxt;

  always_comb begin
    tree_nxt    = tree;
    tree_nxt[0] = ~way[2];
    if (way[2]) tree_nxt[2] = ~way[1];
    else        tree_nxt[1] = ~way[1];
    case (way[2:1])
      2'd0:    tree_nxt[3] = ~way[0];
      2'd1:    tree_nxt[4] = ~way[0];
      2'd2:    tree_nxt[5] = ~way[0];
      default: tree_nxt[6] = ~way[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      tree <= 7'b0;
    else if (upd) tree <= tree_nxt;
  end
endmodule

module plru_replace #(
  parameter int INDEX_WIDTH = 3,
  parameter int WAYS        = 8
) (
  input  logic          clk,
  input  logic          rst,
  plru_replace_if.slave bus
);
  localparam int SETS = 1 << INDEX_WIDTH;

  // The tree shape is hard-wired for three levels.
  if (WAYS != 8) begin : g_bad_ways
    $error("plru_replace: WAYS must be 8");
  end

  logic [SETS-1:0][6:0] tree_q;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    plru_tree_set u_set (
      .clk  (clk),
      .rst  (rst),
      .upd  (bus.access && (bus.index == INDEX_WIDTH'(s))),
      .way  (bus.access_way),
      .tree (tree_q[s])
    );
  end

  // Tree walk on the indexed set.
  logic [6:0] cur;
  logic       v2, v1, v0;
  logic [2:0] tree_way;

  assign cur = tree_q[bus.index];
  assign v2  = cur[0];
  assign v1  = v2 ? cur[2] : cur[1];

  always_comb begin
    case ({v2, v1})
      2'd0:    v0 = cur[3];
      2'd1:    v0 = cur[4];
      2'd2:    v0 = cur[5];
      default: v0 = cur[6];
    endcase
  end

  assign tree_way = {v2, v1, v0};

  // Lowest-numbered invalid way; scanning downward lets way 0 win last.
  logic [2:0] inv_way;
  logic       any_inv;

  always_comb begin
    inv_way = 3'd0;
    for (int n = 7; n >= 0; n--) begin
      if (!bus.valid_in[n]) inv_way = 3'(n);
    end
  end

  assign any_inv               = (bus.valid_in != 8'hFF);
  assign bus.victim            = any_inv ? inv_way : tree_way;
  assign bus.victim_is_invalid = any_inv;

  a_access_known : assert property (@(posedge clk) disable iff (rst)
    bus.access |-> !$isunknown({bus.index, bus.access_way}));
endmodule

// File: tb/tb_plru_replace.sv
module tb_plru_replace;
  localparam int IW   = 3;
  localparam int SETS = 1 << IW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plru_replace_if #(.INDEX_WIDTH(IW)) bus ();

  plru_replace #(.INDEX_WIDTH(IW), .WAYS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: time of the most recent access to each way (0 = never).
  // Victim walk: at each level go to the half whose latest access is older;
  // an untouched subtree counts as oldest, ties (both untouched) go low.
  int unsigned last_use [SETS][8];
  int unsigned stamp = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned grp_max(int s, int lo, int n);
    int unsigned m = 0;
    for (int k = lo; k < lo + n; k++) if (last_use[s][k] > m) m = last_use[s][k];
    return m;
  endfunction

  function automatic int model_victim(int s, logic [7:0] valid, output int inv);
    int lo = 0;
    int size = 8;
    if (valid != 8'hFF) begin
      inv = 1;
      for (int n = 0; n < 8; n++) if (!valid[n]) return n;
    end
    inv = 0;
    while (size > 1) begin
      int half = size / 2;
      if (grp_max(s, lo, half) > grp_max(s, lo + half, half)) lo += half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 8; w++) last_use[s][w] = 0;
  endfunction

  // One cycle, entered and left just after a falling edge. Checks the
  // combinational victim against the model (and an optional literal),
  // then lets the edge happen and updates the model.
  task automatic cycle(int idx, logic [7:0] valid, bit acc, int way, bit r,
                       string tag, int lit);
    int ev, ei;
    bus.index      = IW'(idx);
    bus.valid_in   = valid;
    bus.access     = acc;
    bus.access_way = 3'(way);
    rst            = r;
    #1;
    if (!r) begin
      ev = model_victim(idx, valid, ei);
      chk({tag, "_victim"}, int'(bus.victim), ev);
      chk({tag, "_inv"}, int'(bus.victim_is_invalid), ei);
      if (lit >= 0) chk({tag, "_lit"}, int'(bus.victim), lit);
    end
    @(posedge clk);
    if (r) model_reset();
    else if (acc) begin
      stamp++;
      last_use[idx][way] = stamp;
    end
    @(negedge clk);
  endtask

  int seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

  initial begin
    bus.index = '0; bus.valid_in = 8'hFF; bus.access = 1'b0; bus.access_way = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(0, 8'hFF, 1'b0, 0, 1'b1, "rst", -1);

    for (int s = 0; s < SETS; s++) cycle(s, 8'hFF, 1'b0, 0, 1'b0, "post_rst", 0);

    for (int k = 0; k < 9; k++) cycle(2, 8'hFF, 1'b1, seq[k], 1'b0, "seq", seq[k]);

    cycle(1, 8'b1111_0111, 1'b0, 0, 1'b0, "inv3", 3);
    cycle(1, 8'b0111_1111, 1'b0, 0, 1'b0, "inv7", 7);

    cycle(5, 8'hFF, 1'b1, 0, 1'b0, "iso_acc", 0);
    cycle(6, 8'hFF, 1'b0, 0, 1'b0, "iso_s6", 0);
    cycle(5, 8'hFF, 1'b0, 0, 1'b0, "iso_s5", 4);

    cycle(3, 8'hFF, 1'b1, 0, 1'b0, "same_cyc", 0);
    cycle(3, 8'hFF, 1'b0, 0, 1'b0, "next_cyc", 4);

    cycle(4, 8'hFF, 1'b1, 1, 1'b0, "s4_a", -1);
    cycle(4, 8'hFF, 1'b1, 6, 1'b0, "s4_b", -1);
    cycle(4, 8'hFF, 1'b1, 3, 1'b0, "s4_c", -1);
    cycle(4, 8'hFF, 1'b1, 5, 1'b1, "rst_acc", -1);
    cycle(4, 8'hFF, 1'b0, 0, 1'b0, "rst_dom", 0);
    cycle(2, 8'hFF, 1'b0, 0, 1'b0, "rst_all", 0);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cycle($urandom_range(0, SETS - 1), v, 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 7), 1'($urandom_range(0, 63) == 0), "rnd", -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
